// File: rtl/ibex_counter_wb_buffer.sv
// Counter-result buffer feeding the writeback counter-unit write port in idle writeback cycles.
// Optional starvation drain request built when IBEX_COUNTER_WB_STARVE_EN is defined.
module ibex_counter_wb_buffer #(
    parameter int unsigned Depth       = 2,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [4:0]                 req_waddr_i,
    input  logic [31:0]                req_wdata_i,
    input  logic                       rf_we_core_i,
    output logic                       rf_we_counter_unit_o,
    output logic [31:0]                rf_wdata_counter_unit_o,
    output logic [4:0]                 rf_waddr_counter_unit_o,
    input  logic [4:0]                 hazard_raddr_a_i,
    input  logic [4:0]                 hazard_raddr_b_i,
    input  logic [4:0]                 hazard_waddr_i,
    output logic                       hazard_o,
    output logic                       drain_req_o,
    output logic [$clog2(Depth):0]     occupancy_o
);

    localparam int unsigned PtrW    = $clog2(Depth);
    localparam int unsigned OccW    = PtrW + 1;
    localparam int unsigned StarveW = 4;

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("Depth must be a power of two, 2 or larger");
    end
    if (StarveLimit < 1 || StarveLimit > 15) begin : g_bad_limit
        $error("StarveLimit must be in 1..15");
    end

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OccW-1:0] occ_q, occ_d;
    logic [4:0]      addr_q [Depth];
    logic [4:0]      addr_d [Depth];
    logic [31:0]     data_q [Depth];
    logic [31:0]     data_d [Depth];
    logic            empty, full, enq, deq;
    logic [4:0]      ent_addr;
    logic            hazard;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == OccW'(Depth));
    // Address-0 requests complete the handshake but are never stored.
    assign enq   = req_valid_i & ~full & (req_waddr_i != 5'd0);
    assign deq   = ~empty & ~rf_we_core_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (enq) begin
            addr_d[wr_ptr_q] = req_waddr_i;
            data_d[wr_ptr_q] = req_wdata_i;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({enq, deq})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Hazard scan covers only entries already stored, oldest first from the read pointer.
    always_comb begin
        hazard   = 1'b0;
        ent_addr = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (OccW'(i) < occ_q) begin
                ent_addr = addr_q[rd_ptr_q + PtrW'(i)];
                if (((hazard_raddr_a_i != 5'd0) && (ent_addr == hazard_raddr_a_i)) ||
                    ((hazard_raddr_b_i != 5'd0) && (ent_addr == hazard_raddr_b_i)) ||
                    ((hazard_waddr_i   != 5'd0) && (ent_addr == hazard_waddr_i))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign hazard_o                = hazard;
    assign req_ready_o             = ~full;
    assign occupancy_o             = occ_q;
    assign rf_we_counter_unit_o    = deq;
    assign rf_waddr_counter_unit_o = empty ? 5'd0  : addr_q[rd_ptr_q];
    assign rf_wdata_counter_unit_o = empty ? 32'd0 : data_q[rd_ptr_q];

`ifdef IBEX_COUNTER_WB_STARVE_EN
    logic [StarveW-1:0] starve_q, starve_d;

    // Counts consecutive cycles the head is blocked by core writes, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (empty || deq) begin
            starve_d = '0;
        end else if (rf_we_core_i && (starve_q != StarveW'(StarveLimit))) begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign drain_req_o = ~empty & (starve_q == StarveW'(StarveLimit));
`else
    assign drain_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_counter_wb_buffer.sv
// Testbench for ibex_counter_wb_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_ibex_counter_wb_buffer;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 4;
`ifdef IBEX_COUNTER_WB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_waddr;
    logic [31:0] req_wdata;
    logic        rf_we_core;
    logic        we_cu;
    logic [31:0] wdata_cu;
    logic [4:0]  waddr_cu;
    logic [4:0]  hz_a, hz_b, hz_w;
    logic        hazard;
    logic        drain_req;
    logic [1:0]  occupancy;

    entry_t mq[$];
    int     scnt;
    int     n_total;
    int     n_pass;

    ibex_counter_wb_buffer #(.Depth(DEPTH), .StarveLimit(LIMIT)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .req_valid_i             (req_valid),
        .req_ready_o             (req_ready),
        .req_waddr_i             (req_waddr),
        .req_wdata_i             (req_wdata),
        .rf_we_core_i            (rf_we_core),
        .rf_we_counter_unit_o    (we_cu),
        .rf_wdata_counter_unit_o (wdata_cu),
        .rf_waddr_counter_unit_o (waddr_cu),
        .hazard_raddr_a_i        (hz_a),
        .hazard_raddr_b_i        (hz_b),
        .hazard_waddr_i          (hz_w),
        .hazard_o                (hazard),
        .drain_req_o             (drain_req),
        .occupancy_o             (occupancy)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, updating the queue model from the inputs presented this cycle.
    task automatic tick();
        bit pop, push;
        entry_t e;
        pop  = (mq.size() != 0) && !rf_we_core;
        push = req_valid && (mq.size() != DEPTH) && (req_waddr != 5'd0);
        if (mq.size() == 0 || pop) scnt = 0;
        else if (rf_we_core && scnt < LIMIT) scnt++;
        e.addr = req_waddr;
        e.data = req_wdata;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        @(negedge clk);
    endtask

    function automatic bit model_hazard();
        bit h = 1'b0;
        foreach (mq[i]) begin
            if ((hz_a != 0 && mq[i].addr == hz_a) || (hz_b != 0 && mq[i].addr == hz_b) ||
                (hz_w != 0 && mq[i].addr == hz_w)) h = 1'b1;
        end
        return h;
    endfunction

    task automatic idle_inputs();
        req_valid = 1'b0; req_waddr = '0; req_wdata = '0; rf_we_core = 1'b0;
        hz_a = '0; hz_b = '0; hz_w = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        n_total += 6;
        if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
        if (we_cu !== 1'b0) $display("FAIL reset_we got %b want 0", we_cu); else n_pass++;
        if (hazard !== 1'b0) $display("FAIL reset_hazard got %b want 0", hazard); else n_pass++;
        if (drain_req !== 1'b0) $display("FAIL reset_drain got %b want 0", drain_req); else n_pass++;
        if (occupancy !== 2'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else n_pass++;
        if (wdata_cu !== 32'd0 || waddr_cu !== 5'd0)
            $display("FAIL reset_wb got %h/%0d want 0/0", wdata_cu, waddr_cu); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); scnt = 0;
    endtask

    task automatic test_single_write();
        req_valid = 1'b1; req_waddr = 5'd5; req_wdata = 32'h1234; rf_we_core = 1'b0;
        #1;
        n_total++;
        if (we_cu !== 1'b0) $display("FAIL single_nobypass got %b want 0", we_cu); else n_pass++;
        tick();
        req_valid = 1'b0;
        #1;
        n_total += 2;
        if (we_cu !== 1'b1 || waddr_cu !== 5'd5) $display("FAIL single_we got %b/%0d want 1/5", we_cu, waddr_cu); else n_pass++;
        if (wdata_cu !== 32'h1234) $display("FAIL single_data got %h want 00001234", wdata_cu); else n_pass++;
        tick();
        #1;
        n_total++;
        if (occupancy !== 2'd0 || we_cu !== 1'b0) $display("FAIL single_empty got occ %0d we %b want 0/0", occupancy, we_cu); else n_pass++;
    endtask

    task automatic test_fill_release();
        rf_we_core = 1'b1;
        req_valid = 1'b1; req_waddr = 5'd3; req_wdata = 32'hAAAA_0003;
        tick();
        req_waddr = 5'd4; req_wdata = 32'hBBBB_0004;
        tick();
        req_waddr = 5'd9; req_wdata = 32'hDEAD_0009;
        #1;
        n_total += 2;
        if (req_ready !== 1'b0 || occupancy !== 2'd2) $display("FAIL fill_full got ready %b occ %0d want 0/2", req_ready, occupancy); else n_pass++;
        if (we_cu !== 1'b0) $display("FAIL fill_blocked got %b want 0", we_cu); else n_pass++;
        tick();
        req_valid = 1'b0; rf_we_core = 1'b0;
        #1;
        n_total++;
        if (we_cu !== 1'b1 || waddr_cu !== 5'd3 || wdata_cu !== 32'hAAAA_0003)
            $display("FAIL fill_first got %b/%0d/%h want 1/3/aaaa0003", we_cu, waddr_cu, wdata_cu); else n_pass++;
        tick();
        #1;
        n_total++;
        if (we_cu !== 1'b1 || waddr_cu !== 5'd4 || wdata_cu !== 32'hBBBB_0004)
            $display("FAIL fill_second got %b/%0d/%h want 1/4/bbbb0004", we_cu, waddr_cu, wdata_cu); else n_pass++;
        tick();
        #1;
        n_total++;
        if (occupancy !== 2'd0 || we_cu !== 1'b0) $display("FAIL fill_drained got occ %0d we %b want 0/0", occupancy, we_cu); else n_pass++;
    endtask

    task automatic test_zero_addr();
        req_valid = 1'b1; req_waddr = 5'd0; req_wdata = 32'hFFFF_FFFF;
        #1;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL zero_ready got %b want 1", req_ready); else n_pass++;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (occupancy !== 2'd0 || we_cu !== 1'b0) $display("FAIL zero_nowrite got occ %0d we %b want 0/0", occupancy, we_cu); else n_pass++;
            tick();
        end
    endtask

    task automatic test_hazard();
        rf_we_core = 1'b1;
        req_valid = 1'b1; req_waddr = 5'd7; req_wdata = 32'h77;
        hz_a = 5'd7;
        #1;
        n_total++;
        if (hazard !== 1'b0) $display("FAIL hazard_incoming got %b want 0", hazard); else n_pass++;
        tick();
        req_valid = 1'b0; hz_a = 5'd0; hz_b = 5'd7;
        #1;
        n_total++;
        if (hazard !== 1'b1) $display("FAIL hazard_rb got %b want 1", hazard); else n_pass++;
        hz_b = 5'd0; hz_w = 5'd7;
        #1;
        n_total++;
        if (hazard !== 1'b1) $display("FAIL hazard_wa got %b want 1", hazard); else n_pass++;
        hz_a = 5'd0; hz_b = 5'd3; hz_w = 5'd2;
        #1;
        n_total++;
        if (hazard !== 1'b0) $display("FAIL hazard_nomatch got %b want 0", hazard); else n_pass++;
        rf_we_core = 1'b0;
        tick();
        hz_b = 5'd7;
        #1;
        n_total++;
        if (hazard !== 1'b0 || occupancy !== 2'd0) $display("FAIL hazard_drained got %b occ %0d want 0/0", hazard, occupancy); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_starve();
        bit exp;
        rf_we_core = 1'b1;
        req_valid = 1'b1; req_waddr = 5'd12; req_wdata = 32'h5;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            exp = STARVE_EN && (k >= 5);
            #1;
            n_total++;
            if (drain_req !== exp) $display("FAIL starve_cyc%0d got %b want %b", k, drain_req, exp); else n_pass++;
            tick();
        end
        rf_we_core = 1'b0;
        #1;
        n_total++;
        if (we_cu !== 1'b1 || waddr_cu !== 5'd12) $display("FAIL starve_release got %b/%0d want 1/12", we_cu, waddr_cu); else n_pass++;
        tick();
        #1;
        n_total++;
        if (drain_req !== 1'b0 || occupancy !== 2'd0) $display("FAIL starve_drop got %b occ %0d want 0/0", drain_req, occupancy); else n_pass++;
    endtask

    task automatic test_reset_midop();
        rf_we_core = 1'b1;
        req_valid = 1'b1; req_waddr = 5'd10; req_wdata = 32'h10;
        tick();
        req_waddr = 5'd11; req_wdata = 32'h11;
        tick();
        req_valid = 1'b0; hz_a = 5'd10;
        #1;
        n_total++;
        if (occupancy !== 2'd2 || hazard !== 1'b1) $display("FAIL midrst_pre got occ %0d hz %b want 2/1", occupancy, hazard); else n_pass++;
        rf_we_core = 1'b0;
        rst = 1'b1;
        #1;
        n_total += 3;
        if (occupancy !== 2'd0 || req_ready !== 1'b1) $display("FAIL midrst_occ got occ %0d rdy %b want 0/1", occupancy, req_ready); else n_pass++;
        if (we_cu !== 1'b0 || hazard !== 1'b0 || drain_req !== 1'b0)
            $display("FAIL midrst_ctl got we %b hz %b dr %b want 0/0/0", we_cu, hazard, drain_req); else n_pass++;
        if (waddr_cu !== 5'd0 || wdata_cu !== 32'd0) $display("FAIL midrst_wb got %0d/%h want 0/0", waddr_cu, wdata_cu); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); scnt = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (we_cu !== 1'b0 || hazard !== 1'b0) $display("FAIL midrst_stale got we %b hz %b want 0/0", we_cu, hazard); else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        bit     exp_we, exp_drain;
        entry_t h;
        for (int c = 0; c < 400; c++) begin
            req_valid  = ($urandom_range(0, 9) < 6);
            req_waddr  = 5'($urandom_range(0, 7));
            req_wdata  = $urandom;
            rf_we_core = ($urandom_range(0, 9) < 5 + (c / 100) % 2 * 3);
            hz_a       = 5'($urandom_range(0, 7));
            hz_b       = 5'($urandom_range(0, 7));
            hz_w       = 5'($urandom_range(0, 7));
            #1;
            exp_we    = (mq.size() != 0) && !rf_we_core;
            exp_drain = STARVE_EN && (mq.size() != 0) && (scnt == LIMIT);
            if (mq.size() != 0) h = mq[0];
            else begin h.addr = '0; h.data = '0; end
            n_total += 6;
            if (req_ready !== (mq.size() != DEPTH)) $display("FAIL rnd_ready c%0d got %b want %b", c, req_ready, mq.size() != DEPTH); else n_pass++;
            if (occupancy !== 2'(mq.size())) $display("FAIL rnd_occ c%0d got %0d want %0d", c, occupancy, mq.size()); else n_pass++;
            if (we_cu !== exp_we) $display("FAIL rnd_we c%0d got %b want %b", c, we_cu, exp_we); else n_pass++;
            if (waddr_cu !== h.addr || wdata_cu !== h.data)
                $display("FAIL rnd_head c%0d got %0d/%h want %0d/%h", c, waddr_cu, wdata_cu, h.addr, h.data); else n_pass++;
            if (hazard !== model_hazard()) $display("FAIL rnd_hazard c%0d got %b want %b", c, hazard, model_hazard()); else n_pass++;
            if (drain_req !== exp_drain) $display("FAIL rnd_drain c%0d got %b want %b", c, drain_req, exp_drain); else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        scnt    = 0;
        test_reset();
        test_single_write();
        test_fill_release();
        test_zero_addr();
        test_hazard();
        test_starve();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
